// File: rtl/freelist_ctrl_pkg.sv
// freelist_ctrl_pkg: shared sizes and types for the rename free list
package freelist_ctrl_pkg;
  localparam int PHY_REGS = 64;
  localparam int ARCH_REGS = 32;
  localparam int FREE_NUM = PHY_REGS - ARCH_REGS;
  localparam int BRDEPTH = 4;
  localparam int PHY_REG_SEL = $clog2(PHY_REGS);
  localparam int REG_SEL = $clog2(ARCH_REGS);
  localparam int SPECTAG_LEN = $clog2(BRDEPTH);
  localparam int IDX_W = $clog2(FREE_NUM);
  localparam int PTR_W = IDX_W + 1;
  typedef logic [PHY_REG_SEL-1:0] preg_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [SPECTAG_LEN-1:0] tag_t;
endpackage

// File: rtl/freelist_ram.sv
// freelist_ram: free-list storage, two async reads at ra/ra+1, two sync writes, reset to ARCH_REGS+i
module freelist_ram
  import freelist_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  idx_t  ra,
  output preg_t rd_1,
  output preg_t rd_2,
  input  logic  we_1,
  input  idx_t  wa_1,
  input  preg_t wd_1,
  input  logic  we_2,
  input  idx_t  wa_2,
  input  preg_t wd_2
);
  preg_t mem_q [FREE_NUM];
  preg_t mem_d [FREE_NUM];
  always_comb begin
    mem_d = mem_q;
    if (we_1) mem_d[wa_1] = wd_1;
    if (we_2) mem_d[wa_2] = wd_2;
  end
  always_ff @(posedge clk) begin
    if (reset) for (int i = 0; i < FREE_NUM; i++) mem_q[i] <= preg_t'(ARCH_REGS + i);
    else mem_q <= mem_d;
  end
  assign rd_1 = mem_q[ra];
  assign rd_2 = mem_q[idx_t'(ra + 1'b1)];
endmodule

// File: rtl/freelist_ctrl.sv
// freelist_ctrl: 2-wide physical register free list with branch checkpoints
module freelist_ctrl
  import freelist_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  req_1,
  input  logic  req_2,
  input  logic  stall_in,
  output preg_t pd_1,
  output preg_t pd_2,
  output logic  alloc_ok,
  output logic  empty_freelist,
  input  logic  free_1,
  input  preg_t free_pd_1,
  input  logic  free_2,
  input  preg_t free_pd_2,
  input  logic  chk_we,
  input  tag_t  chk_tag,
  input  logic  recover,
  input  tag_t  rec_tag,
  output ptr_t  count
);
  localparam ptr_t FREE_CNT = ptr_t'(FREE_NUM);
  ptr_t head_q, head_d, tail_q, tail_d, head_g, occ;
  ptr_t ckpt_q [BRDEPTH];
  ptr_t ckpt_d [BRDEPTH];
  logic [1:0] need;
  logic v1, v2, a1, a2, ovf;
  preg_t rd_1, rd_2;
  always_comb begin
    need = {1'b0, req_1} + {1'b0, req_2};
    count = tail_q - head_q;
    empty_freelist = need != 2'd0 && count < ptr_t'(need);
    alloc_ok = need != 2'd0 && !empty_freelist && !stall_in && !recover;
    head_g = head_q + (alloc_ok ? ptr_t'(need) : ptr_t'(0));
    head_d = recover ? ckpt_q[rec_tag] : head_g;
    occ = tail_q - head_d;
    v1 = free_1 && free_pd_1 != '0;
    v2 = free_2 && free_pd_2 != '0;
    a1 = v1 && occ < FREE_CNT;
    a2 = v2 && occ + ptr_t'(a1) < FREE_CNT;
    ovf = (v1 && !a1) || (v2 && !a2);
    tail_d = tail_q + ptr_t'(a1) + ptr_t'(a2);
    ckpt_d = ckpt_q;
    if (chk_we && !recover) ckpt_d[chk_tag] = head_g;
    pd_1 = req_1 ? rd_1 : '0;
    pd_2 = req_2 ? (req_1 ? rd_2 : rd_1) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= FREE_CNT;
      for (int i = 0; i < BRDEPTH; i++) ckpt_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      ckpt_q <= ckpt_d;
    end
  end
  freelist_ram u_ram (
    .clk  (clk),
    .reset(reset),
    .ra   (idx_t'(head_q)),
    .rd_1 (rd_1),
    .rd_2 (rd_2),
    .we_1 (a1),
    .wa_1 (idx_t'(tail_q)),
    .wd_1 (free_pd_1),
    .we_2 (a2),
    .wa_2 (idx_t'(tail_q + ptr_t'(a1))),
    .wd_2 (free_pd_2)
  );
  assert property (@(posedge clk) disable iff (reset) !ovf);
endmodule

// File: tb/tb_freelist_ctrl.sv
// tb_freelist_ctrl: table-driven checks of free list allocation, free, checkpoint and recovery
module tb_freelist_ctrl;
  logic clk = 0, reset = 1, req_1 = 0, req_2 = 0, stall_in = 0;
  logic free_1 = 0, free_2 = 0, chk_we = 0, recover = 0;
  logic [5:0] free_pd_1 = 0, free_pd_2 = 0, pd_1, pd_2, count;
  logic [1:0] chk_tag = 0, rec_tag = 0;
  logic alloc_ok, empty_freelist;
  int passed = 0, total = 0;
  typedef struct {
    logic rst, r1, r2, stl, f1;
    logic [5:0] fp1;
    logic f2;
    logic [5:0] fp2;
    logic cw;
    logic [1:0] ct;
    logic rc;
    logic [1:0] rt;
    logic [5:0] p1, p2;
    logic ok, emp;
    logic [5:0] cnt;
  } vec_t;
  vec_t vecs[$];
  freelist_ctrl dut (
    .clk(clk), .reset(reset), .req_1(req_1), .req_2(req_2), .stall_in(stall_in),
    .pd_1(pd_1), .pd_2(pd_2), .alloc_ok(alloc_ok), .empty_freelist(empty_freelist),
    .free_1(free_1), .free_pd_1(free_pd_1), .free_2(free_2), .free_pd_2(free_pd_2),
    .chk_we(chk_we), .chk_tag(chk_tag), .recover(recover), .rec_tag(rec_tag), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    reset = v.rst; req_1 = v.r1; req_2 = v.r2; stall_in = v.stl;
    free_1 = v.f1; free_pd_1 = v.fp1; free_2 = v.f2; free_pd_2 = v.fp2;
    chk_we = v.cw; chk_tag = v.ct; recover = v.rc; rec_tag = v.rt;
    #1;
    chk({tag, ".pd_1"}, pd_1, v.p1);
    chk({tag, ".pd_2"}, pd_2, v.p2);
    chk({tag, ".alloc_ok"}, 6'(alloc_ok), 6'(v.ok));
    chk({tag, ".empty"}, 6'(empty_freelist), 6'(v.emp));
    chk({tag, ".count"}, count, v.cnt);
  endtask
  initial begin
    vecs.push_back('{0,0,0,0,0,0,0,0,0,0,0,0, 0, 0,0,0,32});
    vecs.push_back('{0,1,1,0,0,0,0,0,0,0,0,0,32,33,1,0,32});
    vecs.push_back('{0,0,0,0,0,0,0,0,0,0,0,0, 0, 0,0,0,30});
    vecs.push_back('{1,0,0,0,0,0,0,0,0,0,0,0, 0, 0,0,0,30});
    vecs.push_back('{0,0,1,0,0,0,0,0,0,0,0,0, 0,32,1,0,32});
    vecs.push_back('{0,0,0,0,0,0,0,0,0,0,0,0, 0, 0,0,0,31});
    vecs.push_back('{1,0,0,0,0,0,0,0,0,0,0,0, 0, 0,0,0,31});
    for (int k = 0; k < 16; k++)
      vecs.push_back('{0,1,1,0,0,0,0,0,0,0,0,0,6'(32+2*k),6'(33+2*k),1,0,6'(32-2*k)});
    vecs.push_back('{0,1,1,0,0,0,0,0,0,0,0,0,32,33,0,1, 0});
    vecs.push_back('{0,0,0,0,1,5,1,7,0,0,0,0, 0, 0,0,0, 0});
    vecs.push_back('{0,1,1,0,0,0,0,0,0,0,0,0, 5, 7,1,0, 2});
    vecs.push_back('{0,0,0,0,1,9,0,0,0,0,0,0, 0, 0,0,0, 0});
    vecs.push_back('{0,1,1,0,0,0,0,0,0,0,0,0, 9,35,0,1, 1});
    vecs.push_back('{0,1,0,0,0,0,0,0,0,0,0,0, 9, 0,1,0, 1});
    vecs.push_back('{0,0,0,0,1,0,0,0,0,0,0,0, 0, 0,0,0, 0});
    vecs.push_back('{0,1,0,1,0,0,1,11,0,0,0,0,35, 0,0,1, 0});
    vecs.push_back('{0,1,0,1,0,0,0,0,0,0,0,0,11, 0,0,0, 1});
    vecs.push_back('{0,1,0,0,0,0,0,0,0,0,0,0,11, 0,1,0, 1});
    vecs.push_back('{1,0,0,0,0,0,0,0,0,0,0,0, 0, 0,0,0, 0});
    vecs.push_back('{0,1,1,0,0,0,0,0,1,1,0,0,32,33,1,0,32});
    vecs.push_back('{0,1,1,0,0,0,0,0,0,0,0,0,34,35,1,0,30});
    vecs.push_back('{0,1,1,0,1,9,0,0,1,1,1,1,36,37,0,0,28});
    vecs.push_back('{0,1,1,0,0,0,0,0,0,0,0,0,34,35,1,0,31});
    vecs.push_back('{0,0,0,0,0,0,0,0,0,0,1,1, 0, 0,0,0,29});
    vecs.push_back('{0,0,0,0,0,0,0,0,0,0,0,0, 0, 0,0,0,31});
    vecs.push_back('{0,1,0,0,0,0,0,0,1,3,0,0,34, 0,1,0,31});
    vecs.push_back('{1,1,1,0,1,9,0,0,0,0,0,0,35,36,1,0,30});
    vecs.push_back('{0,1,1,0,0,0,0,0,0,0,0,0,32,33,1,0,32});
    vecs.push_back('{0,0,0,0,0,0,0,0,0,0,1,3, 0, 0,0,0,30});
    vecs.push_back('{0,0,0,0,0,0,0,0,0,0,0,0, 0, 0,0,0,32});
    vecs.push_back('{0,1,1,0,0,0,0,0,0,0,0,0,32,33,1,0,32});
    repeat (2) @(posedge clk);
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));
    for (int s = 0; s < 3; s++)
      apply('{0,1,1,1,0,0,0,0,0,0,0,0,34,35,0,0,30}, $sformatf("stall%0d", s));
    apply('{0,1,1,0,0,0,0,0,0,0,0,0,34,35,1,0,30}, "release");
    apply('{0,0,0,0,0,0,0,0,0,0,0,0, 0, 0,0,0,28}, "after_release");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/freelist_ctrl.md
Name: freelist_ctrl

Overview:
- Physical-register free list manager for the 2-wide rename stage.
- Hands out up to two free physical destination registers per cycle to the rename slots, all-or-nothing.
- Reclaims up to two committed stale mappings per cycle.
- Snapshots its allocation pointer per speculative branch tag and restores it on misprediction.
- Sits between rename_logic (consumer of pd_1/pd_2 and empty_freelist) and the commit/branch-resolution logic.

Parameters:
- PHY_REGS, 64, number of physical registers.
- ARCH_REGS, 32, architectural registers; p0..p(ARCH_REGS-1) are mapped at reset.
- FREE_NUM, PHY_REGS-ARCH_REGS (32), free-list capacity; must be a power of 2.
- BRDEPTH, 4, number of branch checkpoints.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_1  in  1  slot 1 needs a destination register
- req_2  in  1  slot 2 needs a destination register
- stall_in  in  1  downstream stall; no allocation is committed
- pd_1  out  PHY_REG_SEL  register granted to slot 1
- pd_2  out  PHY_REG_SEL  register granted to slot 2
- alloc_ok  out  1  allocation taken this cycle
- empty_freelist  out  1  insufficient free entries for the current request
- free_1  in  1  commit frees free_pd_1
- free_pd_1  in  PHY_REG_SEL  stale register from commit
- free_2  in  1  commit frees free_pd_2
- free_pd_2  in  PHY_REG_SEL  stale register from commit
- chk_we  in  1  take checkpoint
- chk_tag  in  log2(BRDEPTH)  checkpoint slot
- recover  in  1  misprediction; restore checkpoint
- rec_tag  in  log2(BRDEPTH)  checkpoint to restore
- count  out  log2(FREE_NUM)+1  free entries currently held

Behaviour:
- Storage and pointers:
  - Circular buffer of FREE_NUM entries.
  - Head (alloc) and tail (free) pointers are log2(FREE_NUM)+1 bits wide, including a wrap bit.
  - count = tail - head, modulo 2^(log2(FREE_NUM)+1).
- Reset:
  - Entry i = ARCH_REGS+i; head=0; tail=FREE_NUM; count=FREE_NUM.
  - All checkpoints = 0; alloc_ok=0; empty_freelist=0.
  - Reset overrides every other input in the same cycle.
- Request and grant:
  - need = req_1 + req_2.
  - Grant when need>0, count>=need, !stall_in and !recover. A grant asserts alloc_ok combinationally in the same cycle.
  - empty_freelist = need>0 && count<need. It is independent of stall_in.
  - All-or-nothing: one free entry with two requests yields no grant and no head movement.
- Read order and pd outputs:
  - pd_1 = entry[head] when req_1.
  - pd_2 = entry[head+req_1], so a lone req_2 receives entry[head].
  - pd outputs are combinational from the array. They are 0 when the corresponding request is low.
- Pointer update: head += need at the clock edge of a granted cycle.
- Free:
  - free_1 writes entry[tail]; free_2 writes entry[tail+free_1]; tail += free_1+free_2 at the edge.
  - Freed registers become allocatable the next cycle; there is no same-cycle bypass.
  - Frees are accepted unconditionally, including during stall_in, recover or empty.
  - A free of p0 is ignored.
- Checkpoint:
  - chk_we stores the head value after this cycle's allocation (head+need if granted, else head) into slot chk_tag.
  - chk_we together with recover: the checkpoint is dropped.
- Recover:
  - The next-cycle head is ckpt[rec_tag]. Grants are suppressed that cycle.
  - Frees in the same cycle still advance tail.
  - Speculatively allocated registers reappear because the entries are never overwritten: tail cannot pass a restored head, since count stays <= FREE_NUM.
- Overflow guard: a free when count would exceed FREE_NUM is a protocol error. It is ignored, and a simulation-only assertion fires.
- Simultaneous alloc and free: both apply. count_next = count - granted + freed.

Decomposition:
- Shared constants in the existing constants header: PHY_REG_SEL, REG_SEL, BRDEPTH, SPECTAG_LEN, FREE_NUM.
- Sub-module freelist_ram: FREE_NUM x PHY_REG_SEL array, 2 asynchronous read ports (head, head+1), 2 synchronous write ports (tail, tail+1), with a reset-init pattern.
- Checkpoint registers and the pointer FSM live in freelist_ctrl.

Test Plan:
- Reset, then req_1=req_2=1 -> pd_1=32, pd_2=33, alloc_ok=1; next cycle count=30.
- Only req_2=1 after reset -> pd_2=32, pd_1=0; count=31.
- 16 double allocations -> count=0.
  - Next request -> alloc_ok=0, empty_freelist=1, head unchanged.
  - free_1 pd=5 with free_2 pd=7 -> next cycle a double alloc returns 5,7.
- Count=1 with req_1=req_2=1 -> alloc_ok=0, empty_freelist=1. Then req_1 only -> granted.
- Alloc 32,33 with chk_we tag=1; alloc 34,35; recover rec_tag=1 with free_1 pd=9 in the same cycle.
  - Recover cycle: alloc_ok=0.
  - Next cycle count=31 (30 restored + 1 freed); double alloc -> 34,35.
- Reset asserted mid-stream with req and free active -> next cycle count=32; double alloc -> 32,33; checkpoints read 0.
